mips_multicycle_ctrl: RTL and testbench

Moore/Mealy control FSM that sequences the shared multicycle MIPS datapath (PC, IR, register file, ALU, single-port RAM, source muxes) one instruction at a time.
- Decodes opcode/funct.
- Drives every mux select and write strobe.
- Stalls on a memory ready handshake.
- Counts retired instructions.
- Halts on illegal opcodes or memory timeout.

---
 rtl/mips_ctrl_pkg.sv | 61 ++++++
 rtl/mips_multicycle_ctrl_wait.sv | 29 ++
 rtl/mips_multicycle_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control slice.
// Holds opcodes, state codes and mux-select encodings.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADDR  = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXEC     = 4'd7,
    S_RWB      = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JAL      = 4'd11,
    S_JR       = 4'd12,
    S_ADDI_EX  = 4'd13,
    S_ADDI_WB  = 4'd14,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [1:0] RD_RT   = 2'b00;
  localparam logic [1:0] RD_RD   = 2'b01;
  localparam logic [1:0] RD_RA   = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] SB_B    = 2'b00;
  localparam logic [1:0] SB_4    = 2'b01;
  localparam logic [1:0] SB_IMM  = 2'b10;
  localparam logic [1:0] SB_IMM2 = 2'b11;

  localparam logic [1:0] AOP_ADD = 2'b00;
  localparam logic [1:0] AOP_SUB = 2'b01;
  localparam logic [1:0] AOP_FN  = 2'b10;

  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_OUT = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;
  localparam logic [1:0] PCS_A   = 2'b11;

  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) ||
           (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_wait.sv
// mem_wait_timer: counts consecutive stalled memory cycles.
// en=stall this cycle, clr=leave state; expire=last allowed stall.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

  logic [7:0] cnt;

  // The stall that would make the count reach MEM_TIMEOUT.
  assign expire = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= 8'd0;
    else if (clr || !en)
      cnt <= 8'd0;
    else
      cnt <= cnt + 8'd1;
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences datapath strobes/selects.
// In: opcode/funct/zero/mem_ready. Out: strobes, selects, state, counters, flags.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_write_not,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             illegal,
  output logic             mem_fault
);

  state_t st, nxt;
  logic   set_ill;
  logic   set_flt;
  logic   wait_en;
  logic   expire;
  logic   chg;
  logic   retire;

  // Branch resolution on zero happens in the datapath's PC gating.
  logic   unused_zero;
  assign unused_zero = zero;

  assign state   = st;
  assign wait_en = is_mem_state(st) && !mem_ready;
  assign chg     = (nxt != st);
  assign retire  = (nxt == S_FETCH) && (st != S_FETCH) &&
                   (st != S_IDLE);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait (
    .clk   (clk),
    .rst_n (reset),
    .en    (wait_en),
    .clr   (chg),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= S_IDLE;
      retired   <= '0;
      illegal   <= 1'b0;
      mem_fault <= 1'b0;
    end else begin
      st <= nxt;
      if (retire)
        retired <= retired + CNT_W'(1);
      if (set_ill)
        illegal <= 1'b1;
      if (set_flt)
        mem_fault <= 1'b1;
    end
  end

  always_comb begin
    nxt           = st;
    set_ill       = 1'b0;
    set_flt       = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_write_not  = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = RD_RT;
    mem_to_reg    = M2R_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SB_B;
    alu_op        = AOP_ADD;
    pc_source     = PCS_ALU;

    unique case (st)
      S_IDLE: nxt = S_FETCH;

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SB_4;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = S_DECODE;
        end else if (expire) begin
          nxt     = S_HALT;
          set_flt = 1'b1;
        end
      end

      S_DECODE: begin
        alu_src_b = SB_IMM2;
        unique case (1'b1)
          (opcode == OP_RTYPE && funct == FN_JR):
            nxt = S_JR;
          (opcode == OP_RTYPE && funct != FN_JR):
            nxt = S_EXEC;
          (opcode == OP_LW || opcode == OP_SW):
            nxt = S_MEMADDR;
          (opcode == OP_BEQ || opcode == OP_BNE):
            nxt = S_BRANCH;
          (opcode == OP_ADDI):
            nxt = S_ADDI_EX;
          (opcode == OP_J):
            nxt = S_JUMP;
          (opcode == OP_JAL):
            nxt = S_JAL;
          default: begin
            nxt     = S_HALT;
            set_ill = 1'b1;
          end
        endcase
      end

      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SB_IMM;
        nxt = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          nxt = S_MEMWB;
        end else if (expire) begin
          nxt     = S_HALT;
          set_flt = 1'b1;
        end
      end

      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
        nxt        = S_FETCH;
      end

      S_MEMWRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          nxt = S_FETCH;
        end else if (expire) begin
          nxt     = S_HALT;
          set_flt = 1'b1;
        end
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = AOP_FN;
        nxt       = S_RWB;
      end

      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = RD_RD;
        nxt       = S_FETCH;
      end

      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SB_IMM;
        nxt       = S_ADDI_WB;
      end

      S_ADDI_WB: begin
        reg_write = 1'b1;
        nxt       = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = AOP_SUB;
        pc_source     = PCS_OUT;
        pc_write_cond = (opcode == OP_BEQ);
        pc_write_not  = (opcode == OP_BNE);
        nxt           = S_FETCH;
      end

      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCS_JMP;
        nxt       = S_FETCH;
      end

      S_JAL: begin
        reg_write  = 1'b1;
        reg_dst    = RD_RA;
        mem_to_reg = M2R_PC;
        pc_write   = 1'b1;
        pc_source  = PCS_JMP;
        nxt        = S_FETCH;
      end

      S_JR: begin
        pc_write  = 1'b1;
        pc_source = PCS_A;
        nxt       = S_FETCH;
      end

      S_HALT: nxt = S_HALT;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: instruction-level state-sequence model.
// Directed cases plus $urandom instruction mix, timeouts and resets.
module tb_mips_multicycle_ctrl;

  localparam int TMO = 4;

  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;
  localparam logic [5:0] ADI = 6'b001000;
  localparam logic [5:0] JMP = 6'b000010;
  localparam logic [5:0] JAL = 6'b000011;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        pc_write, pc_write_cond, pc_write_not;
  logic        ir_write, mem_read, mem_write, i_or_d;
  logic        reg_write, alu_src_a;
  logic [1:0]  reg_dst, mem_to_reg, alu_src_b;
  logic [1:0]  alu_op, pc_source;
  logic [3:0]  state;
  logic [31:0] retired;
  logic        illegal, mem_fault;

  mips_multicycle_ctrl #(
    .MEM_TIMEOUT(TMO),
    .CNT_W      (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct        (funct),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .pc_write_not (pc_write_not),
    .ir_write     (ir_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .i_or_d       (i_or_d),
    .reg_write    (reg_write),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .pc_source    (pc_source),
    .state        (state),
    .retired      (retired),
    .illegal      (illegal),
    .mem_fault    (mem_fault)
  );

  always #5 clk = ~clk;

  wire [18:0] obs = {pc_write, pc_write_cond, pc_write_not,
                     ir_write, mem_read, mem_write, i_or_d,
                     reg_write, reg_dst, mem_to_reg, alu_src_a,
                     alu_src_b, alu_op, pc_source};

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  typedef struct {
    int   s;
    logic rdy;
  } step_t;

  step_t q[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Control word listed per state straight from the state table.
  function automatic logic [18:0] exp_out(int s, logic [5:0] op,
                                          logic rdy);
    logic pw, pwc, pwn, irw, mr, mw, iod, rw, asa;
    logic [1:0] rd, m2r, asb, aop, pcs;
    {pw, pwc, pwn, irw, mr, mw, iod, rw, asa} = '0;
    {rd, m2r, asb, aop, pcs} = '0;
    case (s)
      1:  begin mr = 1; asb = 1; irw = rdy; pw = rdy; end
      2:  asb = 3;
      3:  begin asa = 1; asb = 2; end
      4:  begin mr = 1; iod = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mw = 1; iod = 1; end
      7:  begin asa = 1; aop = 2; end
      8:  begin rw = 1; rd = 1; end
      9:  begin
            asa = 1; aop = 1; pcs = 1;
            pwc = (op == BEQ); pwn = (op == BNE);
          end
      10: begin pw = 1; pcs = 2; end
      11: begin rw = 1; rd = 2; m2r = 2; pw = 1; pcs = 2; end
      12: begin pw = 1; pcs = 3; end
      13: begin asa = 1; asb = 2; end
      14: rw = 1;
      default: ;
    endcase
    return {pw, pwc, pwn, irw, mr, mw, iod, rw, rd, m2r,
            asa, asb, aop, pcs};
  endfunction

  function automatic step_t mk(int s, logic r);
    step_t t;
    t.s = s;
    t.rdy = r;
    return t;
  endfunction

  task automatic add_wait(int s, int w);
    for (int i = 0; i < w; i++) q.push_back(mk(s, 1'b0));
    q.push_back(mk(s, 1'b1));
  endtask

  // Expected state visits of one instruction; waits are stall counts.
  task automatic build(logic [5:0] op, logic [5:0] fn,
                       int wf, int wm);
    q.delete();
    add_wait(1, wf);
    q.push_back(mk(2, 1'($urandom)));
    if (op == RT && fn == 6'b001000) begin
      q.push_back(mk(12, 1'($urandom)));
    end else if (op == RT) begin
      q.push_back(mk(7, 1'($urandom)));
      q.push_back(mk(8, 1'($urandom)));
    end else if (op == LW) begin
      q.push_back(mk(3, 1'($urandom)));
      add_wait(4, wm);
      q.push_back(mk(5, 1'($urandom)));
    end else if (op == SW) begin
      q.push_back(mk(3, 1'($urandom)));
      add_wait(6, wm);
    end else if (op == BEQ || op == BNE) begin
      q.push_back(mk(9, 1'($urandom)));
    end else if (op == ADI) begin
      q.push_back(mk(13, 1'($urandom)));
      q.push_back(mk(14, 1'($urandom)));
    end else if (op == JMP) begin
      q.push_back(mk(10, 1'($urandom)));
    end else begin
      q.push_back(mk(11, 1'($urandom)));
    end
  endtask

  task automatic play(string tag, logic [5:0] op);
    foreach (q[i]) begin
      mem_ready = q[i].rdy;
      zero = 1'($urandom);
      #1;
      chk({tag, ".state"}, 64'(state), 64'(q[i].s));
      chk({tag, ".out"}, 64'(obs), 64'(exp_out(q[i].s, op, q[i].rdy)));
      if (i == 0) begin
        chk({tag, ".retired"}, 64'(retired), 64'(exp_ret));
        chk({tag, ".flags"}, 64'({illegal, mem_fault}), 64'(0));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(string tag, logic [5:0] op,
                           logic [5:0] fn, int wf, int wm);
    opcode = op;
    funct = fn;
    build(op, fn, wf, wm);
    play(tag, op);
    exp_ret++;
  endtask

  task automatic halt_hold(string tag, int n, logic ill, logic flt);
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom);
      zero = 1'($urandom);
      #1;
      chk({tag, ".hstate"}, 64'(state), 64'(15));
      chk({tag, ".hout"}, 64'(obs), 64'(0));
      @(posedge clk);
      #1;
    end
    chk({tag, ".hflags"}, 64'({illegal, mem_fault}), 64'({ill, flt}));
    chk({tag, ".hret"}, 64'(retired), 64'(exp_ret));
  endtask

  task automatic do_reset(string tag);
    reset = 1'b0;
    #1;
    chk({tag, ".rstate"}, 64'(state), 64'(0));
    chk({tag, ".rout"}, 64'(obs), 64'(0));
    chk({tag, ".rflags"}, 64'({illegal, mem_fault}), 64'(0));
    chk({tag, ".rret"}, 64'(retired), 64'(0));
    exp_ret = 0;
    #1;
    reset = 1'b1;
    #1;
    chk({tag, ".idle"}, 64'(state), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [5:0] op, fn;
    ops = '{RT, LW, SW, BEQ, BNE, ADI, JMP, JAL};
    reset = 1'b0;
    opcode = '0;
    funct = '0;
    zero = 1'b0;
    mem_ready = 1'b0;
    #12;
    chk("reset.state", 64'(state), 64'(0));
    chk("reset.out", 64'(obs), 64'(0));
    chk("reset.ret", 64'(retired), 64'(0));
    chk("reset.flags", 64'({illegal, mem_fault}), 64'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_instr("add", RT, 6'b100000, 0, 0);
    run_instr("lw", LW, 6'd0, 0, 3);
    run_instr("beq", BEQ, 6'd0, 0, 0);
    run_instr("bne", BNE, 6'd0, 0, 0);
    run_instr("jal", JAL, 6'd0, 0, 0);
    run_instr("jr", RT, 6'b001000, 0, 0);
    run_instr("sw", SW, 6'd0, 1, TMO - 1);
    run_instr("fetch_edge", ADI, 6'd0, TMO - 1, 0);
    run_instr("jump", JMP, 6'd0, 2, 0);

    for (int k = 0; k < 60; k++) begin
      op = ops[$urandom_range(0, 7)];
      fn = 6'($urandom);
      if (op == RT && $urandom_range(0, 3) == 0)
        fn = 6'b001000;
      run_instr("rand", op, fn,
                $urandom_range(0, TMO - 1),
                $urandom_range(0, TMO - 1));
    end

    opcode = 6'b111111;
    q.delete();
    q.push_back(mk(1, 1'b1));
    q.push_back(mk(2, 1'b0));
    play("illegal", opcode);
    halt_hold("illegal", 20, 1'b1, 1'b0);
    do_reset("rst1");

    opcode = RT;
    funct = 6'b100000;
    q.delete();
    for (int i = 0; i < TMO; i++) q.push_back(mk(1, 1'b0));
    play("ftmo", opcode);
    halt_hold("ftmo", 5, 1'b0, 1'b1);
    do_reset("rst2");

    run_instr("after_rst", RT, 6'b100010, 0, 0);
    opcode = LW;
    q.delete();
    q.push_back(mk(1, 1'b1));
    q.push_back(mk(2, 1'b0));
    q.push_back(mk(3, 1'b0));
    for (int i = 0; i < TMO; i++) q.push_back(mk(4, 1'b0));
    play("mtmo", opcode);
    halt_hold("mtmo", 5, 1'b0, 1'b1);
    do_reset("rst3");

    opcode = RT;
    funct = 6'b100101;
    q.delete();
    q.push_back(mk(1, 1'b1));
    q.push_back(mk(2, 1'b1));
    play("mid", opcode);
    #1;
    chk("mid.exec", 64'(state), 64'(7));
    do_reset("rst_mid");
    run_instr("post_mid", SW, 6'd0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
